// File: rtl/codec_tx_float.sv
// Stereo codec transmit path: converts 24-bit floats (1/7/16, bias 63) to
// saturated Q1.23 PCM and serialises left/right pairs as an I2S master.
module codec_tx_float #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] float_in,
  input  logic        float_in_valid,
  output logic        float_in_ready,
  input  logic        flag_clr,
  output logic        codec_bclk,
  output logic        codec_lrclk,
  output logic        codec_sdata,
  output logic        sat_flag,
  output logic        underrun_flag
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_nxt;
  logic             bclk_fall;
  logic             frame_load;
  logic             pair_ready;
  logic             accept;

  ch_e              wr_ch;
  logic [1:0]       full;
  logic [23:0]      slot_l;
  logic [23:0]      slot_r;
  logic [23:0]      sr_l;
  logic [23:0]      sr_r;

  logic [6:0]       conv_exp;
  logic [23:0]      mant_ext;
  logic [23:0]      conv_mag;
  logic [23:0]      conv_val;
  logic             conv_sat;

  logic [4:0]       pos_nxt;
  logic [4:0]       sr_idx;
  logic [23:0]      sr_sel;
  logic             sdata_nxt;

  assign float_in_ready = (wr_ch == CH_LEFT) ? ~full[0] : ~full[1];
  assign accept         = float_in_valid & float_in_ready;
  assign bclk_fall      = (div_cnt == DIV_LAST) & codec_bclk;
  assign frame_load     = bclk_fall & (bit_cnt == 6'd63);
  assign pair_ready     = &full;
  assign bit_nxt        = bit_cnt + 6'd1;

  // Float to Q1.23 with saturation; sign ignored for zero exponent.
  always_comb begin
    conv_exp = float_in[22:16];
    mant_ext = {7'd0, 1'b1, float_in[15:0]};
    conv_mag = '0;
    conv_sat = 1'b0;
    if (conv_exp == 7'd0) begin
      conv_mag = '0;
    end else if (conv_exp >= 7'd63) begin
      conv_sat = 1'b1;
    end else if (conv_exp >= 7'd56) begin
      conv_mag = mant_ext << (conv_exp - 7'd56);
    end else if (conv_exp >= 7'd40) begin
      conv_mag = mant_ext >> (7'd56 - conv_exp);
    end
    if (conv_sat) begin
      conv_val = float_in[23] ? 24'h800000 : 24'h7FFFFF;
    end else if (float_in[23]) begin
      conv_val = ~conv_mag + 24'd1;
    end else begin
      conv_val = conv_mag;
    end
  end

  // Data bit for the position the next falling edge moves to.
  // The register contents are held and indexed rather than physically shifted.
  always_comb begin
    pos_nxt   = bit_nxt[4:0];
    sr_sel    = bit_nxt[5] ? sr_r : sr_l;
    sr_idx    = 5'd24 - pos_nxt;
    sdata_nxt = 1'b0;
    if ((pos_nxt >= 5'd1) && (pos_nxt <= 5'd24)) begin
      sdata_nxt = sr_sel[sr_idx];
    end
  end

  // Bit clock divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      codec_bclk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      codec_bclk <= ~codec_bclk;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

  // Frame position, word select, serial data and frame load on bclk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 6'd63;
      codec_lrclk <= 1'b1;
      codec_sdata <= 1'b0;
      sr_l        <= '0;
      sr_r        <= '0;
    end else if (bclk_fall) begin
      bit_cnt     <= bit_nxt;
      codec_lrclk <= bit_nxt[5];
      codec_sdata <= sdata_nxt;
      if (bit_cnt == 6'd63) begin
        if (pair_ready) begin
          sr_l <= slot_l;
          sr_r <= slot_r;
        end else begin
          sr_l <= '0;
          sr_r <= '0;
        end
      end
    end
  end

  // Channel slots: load clears only on a complete pair; acceptance writes after.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ch  <= CH_LEFT;
      full   <= '0;
      slot_l <= '0;
      slot_r <= '0;
    end else begin
      if (frame_load && pair_ready) begin
        full <= 2'b00;
      end
      if (accept) begin
        if (wr_ch == CH_LEFT) begin
          slot_l  <= conv_val;
          full[0] <= 1'b1;
          wr_ch   <= CH_RIGHT;
        end else begin
          slot_r  <= conv_val;
          full[1] <= 1'b1;
          wr_ch   <= CH_LEFT;
        end
      end
    end
  end

  // Sticky flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag      <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      if (accept && conv_sat) begin
        sat_flag <= 1'b1;
      end else if (flag_clr) begin
        sat_flag <= 1'b0;
      end
      if (frame_load && !pair_ready) begin
        underrun_flag <= 1'b1;
      end else if (flag_clr) begin
        underrun_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codec_tx_float.sv
// Self-checking bench for codec_tx_float: directed pair table, hand-written
// underrun / backpressure / reset sequences, and randomized traffic against
// an arithmetic reference model with an I2S receiver decoding the serial line.
module tb_codec_tx_float;

  localparam int D     = 4;
  localparam int FRAME = 128 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] float_in;
  logic        float_in_valid;
  logic        float_in_ready;
  logic        flag_clr;
  logic        codec_bclk;
  logic        codec_lrclk;
  logic        codec_sdata;
  logic        sat_flag;
  logic        underrun_flag;

  always #5 clk = ~clk;

  codec_tx_float #(.BCLK_DIV(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .float_in       (float_in),
    .float_in_valid (float_in_valid),
    .float_in_ready (float_in_ready),
    .flag_clr       (flag_clr),
    .codec_bclk     (codec_bclk),
    .codec_lrclk    (codec_lrclk),
    .codec_sdata    (codec_sdata),
    .sat_flag       (sat_flag),
    .underrun_flag  (underrun_flag)
  );

  typedef struct { logic ch; logic [23:0] w; } exp_t;
  typedef struct { logic [23:0] l_in; logic [23:0] r_in; logic [23:0] l_exp; logic [23:0] r_exp; logic sat; } vec_t;

  exp_t        expq[$];
  vec_t        vecs[6];

  int          total = 0;
  int          bad = 0;

  // Reference model state (transaction level, timing from edge arithmetic)
  int          n = 0;
  logic [1:0]  m_full = '0;
  logic        m_wr = 1'b0;
  logic [23:0] m_slot[2];
  logic        m_sat = 1'b0;
  logic        m_und = 1'b0;
  int          load_cnt = 0;
  int          pushed = 0;
  int          captured = 0;
  bit          last_acc;
  logic [23:0] last_word[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=no-event required=event-within-bound (t=%0t)", name, $time);
  endtask

  // value = (1 + m/2^16) * 2^(e-63), scaled by 2^23 and truncated.
  function automatic logic [23:0] ref_pcm(input logic [23:0] f, output logic sat);
    int  e;
    real v;
    int  mag;
    e   = int'(f[22:16]);
    sat = 1'b0;
    if (e == 0) return 24'd0;
    v = (65536.0 + real'(f[15:0])) * (2.0 ** (e - 56));
    if (v >= 8388608.0) begin
      sat = 1'b1;
      return f[23] ? 24'h800000 : 24'h7FFFFF;
    end
    mag = $rtoi(v);
    return f[23] ? 24'(-mag) : 24'(mag);
  endfunction

  function automatic int m_bit();
    int f;
    f = n / (2 * D);
    return (f == 0) ? 63 : (63 + f) % 64;
  endfunction

  function automatic logic [23:0] rand_float();
    logic [6:0] e;
    int         r;
    r = int'($urandom % 8);
    if (r == 0)      e = 7'd0;
    else if (r == 1) e = 7'($urandom_range(63, 127));
    else if (r == 2) e = 7'($urandom_range(1, 39));
    else             e = 7'($urandom_range(40, 62));
    return {1'($urandom), e, 16'($urandom)};
  endfunction

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    int   nn;
    logic acc;
    logic sat_e;
    logic und_e;
    nn    = rst ? 0 : n + 1;
    acc   = 1'b0;
    sat_e = 1'b0;
    und_e = 1'b0;
    if (rst) begin
      m_full = '0;
      m_wr   = 1'b0;
      m_sat  = 1'b0;
      m_und  = 1'b0;
      expq.delete();
      pushed = captured;
    end else begin
      acc = float_in_valid && !m_full[m_wr];
      if ((nn % FRAME) == 2 * D) begin
        load_cnt++;
        if (&m_full) begin
          expq.push_back('{1'b0, m_slot[0]});
          expq.push_back('{1'b1, m_slot[1]});
          m_full = '0;
        end else begin
          expq.push_back('{1'b0, 24'd0});
          expq.push_back('{1'b1, 24'd0});
          und_e = 1'b1;
        end
        pushed += 2;
      end
      if (acc) begin
        m_slot[m_wr] = ref_pcm(float_in, sat_e);
        m_full[m_wr] = 1'b1;
        m_wr = ~m_wr;
      end
      m_sat = sat_e | (m_sat & ~flag_clr);
      m_und = und_e | (m_und & ~flag_clr);
    end
    n = nn;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bclk", codec_bclk, 32'((n / D) % 2));
    chk("lrclk", codec_lrclk, 32'(m_bit() >= 32));
    chk("ready", float_in_ready, 32'(!m_full[m_wr]));
    chk("sat_flag", sat_flag, m_sat);
    chk("underrun_flag", underrun_flag, m_und);
  endtask

  task automatic wait_load(input string name);
    int start;
    start = load_cnt;
    for (int i = 0; i < FRAME + 50 && load_cnt == start; i++) tick();
    if (load_cnt == start) timeout(name);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < FRAME + 50 && m_full != 2'b00; i++) tick();
    if (m_full != 2'b00) timeout(name);
  endtask

  task automatic wait_capture(input string name);
    int target;
    target = pushed;
    for (int i = 0; i < 2 * FRAME && captured < target; i++) tick();
    if (captured < target) timeout(name);
  endtask

  task automatic send(input logic [23:0] f);
    bit got;
    got = 1'b0;
    float_in = f;
    float_in_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      got = !m_full[m_wr];
      tick();
    end
    float_in_valid = 1'b0;
    if (!got) timeout("send_accept");
  endtask

  // I2S receiver: sample on bclk rising edges, word position from lrclk changes.
  int          mpos = 100;
  logic        mprev_b = 1'b0;
  logic        mprev_lr = 1'b1;
  logic [23:0] mword = '0;
  logic        mpad = 1'b0;
  exp_t        mexp;

  always @(negedge clk) begin
    if (rst) begin
      mpos     = 100;
      mprev_b  = 1'b0;
      mprev_lr = 1'b1;
    end else begin
      if (codec_bclk === 1'b1 && mprev_b === 1'b0) begin
        if (codec_lrclk !== mprev_lr) begin
          mpos  = 0;
          mword = '0;
          mpad  = (codec_sdata !== 1'b0);
        end else begin
          if (mpos < 100) mpos++;
          if (mpos >= 1 && mpos <= 24) mword = {mword[22:0], codec_sdata};
          else if (codec_sdata !== 1'b0) mpad = 1'b1;
        end
        mprev_lr = codec_lrclk;
        if (mpos == 31) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sdata_word actual=%0h required=no-word-pending (t=%0t)", mword, $time);
          end else begin
            mexp = expq.pop_front();
            chk("sdata_channel", mprev_lr, mexp.ch);
            chk("sdata_word", mword, mexp.w);
            chk("sdata_padding", mpad, 1'b0);
          end
          last_word[mprev_lr] = mword;
          captured++;
        end
      end
      mprev_b = codec_bclk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int start;
    int cyc;

    vecs[0] = '{24'h3D8000, 24'hBE0000, 24'h300000, 24'hC00000, 1'b0};
    vecs[1] = '{24'h469040, 24'h000000, 24'h7FFFFF, 24'h000000, 1'b1};
    vecs[2] = '{24'h3754C9, 24'hB754C9, 24'h00AA64, 24'hFF559C, 1'b0};
    vecs[3] = '{24'hC70000, 24'h3EFFFF, 24'h800000, 24'h7FFFC0, 1'b1};
    vecs[4] = '{24'h280000, 24'hA80000, 24'h000001, 24'hFFFFFF, 1'b0};
    vecs[5] = '{24'h27FFFF, 24'h3F0000, 24'h000000, 24'h7FFFFF, 1'b1};

    rst = 1'b1;
    float_in = '0;
    float_in_valid = 1'b0;
    flag_clr = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_sdata", codec_sdata, 1'b0);
    chk("reset_lrclk", codec_lrclk, 1'b1);
    chk("reset_ready", float_in_ready, 1'b1);
    rst = 1'b0;

    // Directed pairs; left sample is sent with flag_clr high (set must win)
    foreach (vecs[k]) begin
      wait_load("vec_wait_frame");
      flag_clr = 1'b1;
      tick();
      send(vecs[k].l_in);
      flag_clr = 1'b0;
      send(vecs[k].r_in);
      wait_empty("vec_wait_load");
      chk("vec_underrun", underrun_flag, 1'b0);
      chk("vec_sat", sat_flag, vecs[k].sat);
      wait_capture("vec_capture");
      chk("vec_left_word", last_word[0], vecs[k].l_exp);
      chk("vec_right_word", last_word[1], vecs[k].r_exp);
      if (vecs[k].sat) begin
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("sat_after_clr", sat_flag, 1'b0);
      end
    end

    // Underrun: only a left sample before the frame start
    wait_load("und_wait_frame");
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    send(24'h3D8000);
    wait_load("und_load");
    chk("und_flag_set", underrun_flag, 1'b1);
    chk("und_ready_right", float_in_ready, 1'b1);
    wait_capture("und_capture");
    chk("und_left_zero", last_word[0], 24'h000000);
    chk("und_right_zero", last_word[1], 24'h000000);
    send(24'hBE0000);
    wait_empty("und_pair_load");
    wait_capture("und_pair_capture");
    chk("und_left_kept", last_word[0], 24'h300000);
    chk("und_right_word", last_word[1], 24'hC00000);

    // Backpressure: valid held high, two acceptances per frame
    float_in = rand_float();
    float_in_valid = 1'b1;
    wait_load("bp_sync");
    for (int f = 0; f < 4; f++) begin
      start = load_cnt;
      cnt = 0;
      for (int i = 0; i < FRAME + 50 && load_cnt == start; i++) begin
        if (float_in_valid && float_in_ready) cnt++;
        tick();
        if (last_acc) float_in = rand_float();
      end
      if (load_cnt == start) timeout("bp_frame");
      else chk("bp_accepts_per_frame", 32'(cnt), 32'd2);
    end
    float_in_valid = 1'b0;

    // Randomized traffic with occasional flag clears
    for (int i = 0; i < 4 * FRAME; i++) begin
      float_in_valid = ($urandom % 3) == 0;
      flag_clr = ($urandom % 40) == 0;
      float_in = rand_float();
      tick();
    end
    float_in_valid = 1'b0;
    flag_clr = 1'b0;

    // Reset in the middle of the right half
    cyc = 0;
    for (int i = 0; i < FRAME + 50 && m_bit() != 40; i++) tick();
    if (m_bit() != 40) timeout("rst_reach_bit40");
    rst = 1'b1;
    tick();
    chk("midrst_lrclk", codec_lrclk, 1'b1);
    chk("midrst_bclk", codec_bclk, 1'b0);
    chk("midrst_sdata", codec_sdata, 1'b0);
    chk("midrst_ready", float_in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3 * D && codec_bclk !== 1'b1; i++) begin
      tick();
      cyc++;
    end
    chk("midrst_first_rise", 32'(cyc), 32'(D));
    for (int i = 0; i < 3 * D && codec_bclk !== 1'b0; i++) begin
      tick();
      cyc++;
    end
    chk("midrst_first_fall", 32'(cyc), 32'(2 * D));
    chk("midrst_first_lrclk", codec_lrclk, 1'b0);
    chk("midrst_first_underrun", underrun_flag, 1'b1);
    send(24'h3754C9);
    send(24'hB754C9);
    wait_empty("midrst_pair_load");
    wait_capture("midrst_capture");
    chk("midrst_left_word", last_word[0], 24'h00AA64);
    chk("midrst_right_word", last_word[1], 24'hFF559C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codec_tx_float.md
# codec_tx_float

Stereo codec transmit path. It accepts 24-bit floats (1 sign, 7 exponent with bias 63, 16 mantissa), the same format produced on `float_out` by `top_level`. It converts each value to 24-bit signed Q1.23 PCM with saturation and shifts the samples out MSB-first on an I2S-format serial interface that it masters (bit clock and word select generated internally). It sits between the float datapath output and the external audio codec.

## Interface
- `BCLK_DIV`, default 4: `clk` cycles per half period of `codec_bclk`; must be ≥2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `float_in` in 24: float sample `{s, e[6:0], m[15:0]}`.
- `float_in_valid` in 1: `float_in` is valid.
- `float_in_ready` out 1: the block can accept a sample this cycle.
- `flag_clr` in 1: clears the sticky flags.
- `codec_bclk` out 1: serial bit clock.
- `codec_lrclk` out 1: word select; 0 = left, 1 = right.
- `codec_sdata` out 1: serial data.
- `sat_flag` out 1: sticky; a sample was saturated.
- `underrun_flag` out 1: sticky; a frame was sent without a full stereo pair.

## Operation
**Conversion** (registered on acceptance):
- `M = {1, m}` (17 bit).
- `e == 0` gives result 0. There are no denormals, and the sign is ignored.
- `e >= 63` saturates: positive gives 0x7FFFFF, negative gives 0x800000, and `sat_flag` is set.
- `56 <= e <= 62` gives magnitude `M << (e-56)`.
- `e < 56` gives magnitude `M >> (56-e)`, truncated toward zero. A shift of 17 or more gives 0.
- Negative values are the two's complement of the magnitude, so a magnitude of 0 gives 0.

**Input handshake:**
- A sample is accepted when `float_in_valid && float_in_ready`.
- Accepted samples alternate between channels: left first after reset, then right, then left, and so on. A write channel pointer `wr_ch` toggles on each acceptance.
- Each channel has a one-sample slot with a full bit.
- `float_in_ready = ~full[wr_ch]`.
- An acceptance writes the converted value into `slot[wr_ch]` and sets its full bit.

**Serial framing:**
- `div_cnt` counts 0..BCLK_DIV-1. On wrap, `codec_bclk` toggles.
- On each 1→0 transition of `codec_bclk`, `bit_cnt` (0..63) increments, wrapping 63→0.
- `codec_lrclk = (bit_cnt >= 32)`, registered on the same edge.
- Within each 32-bit half, position `p = bit_cnt[4:0]`:
  - p = 1..24: `codec_sdata` carries shift register bit `24-p` (MSB at p = 1, one bclk after the lrclk change, I2S style).
  - p = 0 and p = 25..31: `codec_sdata` is 0.

**Frame load** (on the edge where `bit_cnt` goes 63→0):
- If both full bits are set, copy both slots into the left/right shift registers and clear both full bits.
- Otherwise, load zeros into both shift registers, set `underrun_flag`, and leave the slots and full bits untouched.
- Only the full bits held before the edge are considered. An acceptance on the same cycle completes its write afterwards, so that sample waits for the next frame.

**Flags:**
- `sat_flag` and `underrun_flag` are cleared by `flag_clr`.
- If a set event and `flag_clr` occur in the same cycle, the set wins.

## Timing
**Reset values:**
- `div_cnt = 0`, `codec_bclk = 0`, `bit_cnt = 63`, `codec_lrclk = 1`, `codec_sdata = 0`.
- `wr_ch = left`, both full bits 0, shift registers 0, both flags 0.
- `float_in_ready = 1` one cycle after `rst` deasserts.

**Clocking:**
- `codec_bclk` first rises BCLK_DIV cycles after reset release and first falls at 2·BCLK_DIV. That first falling edge is the first frame start: `bit_cnt = 0`, `codec_lrclk = 0`.
- The first frame sees empty slots and therefore asserts `underrun_flag`.
- A frame is 64·2·BCLK_DIV `clk` cycles (512 at the default).
- All serial outputs change only on falling-edge cycles and are stable across the `codec_bclk` rising edge.

**Latency and backpressure:**
- A sample is valid in its slot one cycle after acceptance.
- With both slots full, `float_in_ready` stays low until the next frame load. It goes high the cycle after the load for the left slot (`wr_ch` is left again).

**Reset mid-frame:** reset aborts the frame immediately. Outputs return to their reset values on the next edge and pending samples are discarded.

## Test plan
- **Basic pair:** left 0x3D8000 (0.375), right 0xBE0000 (−0.5). Required: left word 0x300000 and right word 0xC00000, shifted MSB-first at p = 1..24, zeros elsewhere, no flags set after the first frame.
- **Saturation and zero:** left 0x469040 (200.125), right 0x000000. Required: 0x7FFFFF and 0x000000, `sat_flag = 1`. Then assert `flag_clr` and check `sat_flag = 0`.
- **Small value:** left 0x3754C9 (0.0052), right 0xB754C9. Required: 0x00AA64 and 0xFF559C.
- **Underrun:** supply only a left sample before frame start. Required: both words transmitted as zero, `underrun_flag = 1`, and the left slot still full with that sample. After the right sample arrives, the next frame sends the pair.
- **Backpressure:** hold `float_in_valid` high continuously. Required: exactly two acceptances per 512-cycle frame, with `float_in_ready` low between the second acceptance and the frame load.
- **Reset mid-frame:** assert `rst` at `bit_cnt = 40`. Required: `codec_lrclk = 1`, `codec_bclk = 0`, `codec_sdata = 0` after the reset edge, and framing restarts exactly as from power-up.
